filter_coef_sequencer: RTL
==========================

Name: filter_coef_sequencer

Overview:
- Initiator side of the FILTER coefficient/sample interface.
- Upstream (allophone/parameter logic) writes 12 sign-magnitude coefficients into a shadow bank and commits the frame.
- On each sample tick the block does three things in order:
  - streams a committed frame serially into FILTER (coef_load, one coefficient per cycle);
  - pulses start with the excitation sample;
  - waits for done and captures sig_out as the output sample.

Parameters:
- NCOEF, 12: coefficients per frame (6 sections × a1,a2); order index 0..11 = s1.a1, s1.a2, …, s6.a2.
- COEF_W, 10: coefficient width, sign-magnitude (bit 9 sign, 8:0 magnitude).
- SIG_W, 16: signed sample width.
- TIMEOUT, 64: maximum cycles in WAIT before abort (only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_an  in  1  asynchronous active-low reset.
- coef_wr  in  1  write strobe into the shadow bank.
- coef_waddr  in  4  shadow index 0..11; 12..15 ignored.
- coef_wdata  in  COEF_W  coefficient value.
- frame_commit  in  1  marks the shadow bank as a pending frame.
- frame_busy  out  1  high from an accepted commit until its load completes.
- sample_tick  in  1  one-cycle sample-rate enable.
- exc_in  in  SIG_W  excitation sample, sampled on an accepted tick.
- filt_coef  out  COEF_W  to FILTER coef_in.
- filt_coef_load  out  1  to FILTER coef_load.
- filt_sig  out  SIG_W  to FILTER sig_in.
- filt_start  out  1  to FILTER start.
- filt_done  in  1  from FILTER done.
- filt_out  in  SIG_W  from FILTER sig_out.
- sample_out  out  SIG_W  last captured output sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- overrun  out  1  sticky: a tick arrived while not IDLE.
- timeout_err  out  1  sticky: WAIT aborted.

Behaviour:
- Reset (async, rst_an=0):
  - state=IDLE, index=0, pending=0;
  - all outputs 0;
  - shadow bank cleared to 0.
- Shadow writes:
  - coef_wr with addr<12 and frame_busy=0 writes shadow[addr] on the clock edge.
  - Writes while frame_busy=1 are ignored.
  - frame_commit with frame_busy=0 sets pending=1 and frame_busy=1. A commit while busy is ignored.
  - If coef_wr and frame_commit occur in the same cycle, the write lands first and is included in the frame.
- FSM IDLE:
  - On sample_tick, register exc_in into filt_sig.
  - If pending=1 → LOAD with index=0; otherwise → START.
- FSM LOAD:
  - filt_coef_load=1 and filt_coef=shadow[index] for exactly NCOEF consecutive cycles; index increments each cycle.
  - After index 11: clear pending and frame_busy, deassert filt_coef_load, → START.
  - LOAD always presents a complete 12-coefficient frame; there are no partial frames.
- FSM START:
  - filt_start=1 for one cycle, → WAIT.
  - filt_sig is held stable from the tick until exit from WAIT.
- FSM WAIT:
  - On filt_done=1: sample_out<=filt_out, sample_valid=1 next cycle, → IDLE.
  - Latency:
    - tick to start is 1 cycle (no frame) or 13 cycles (frame pending);
    - done to sample_valid is 1 cycle.
- sample_tick outside IDLE: tick dropped, overrun<=1 (sticky until reset).
- filt_done outside WAIT is ignored.
- Reset mid-LOAD: the frame is lost (pending=0); upstream must rewrite and recommit.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: FILTER_COEF_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter resets on entry to WAIT.
  - If TIMEOUT cycles elapse without filt_done: → IDLE, timeout_err<=1, sample_out unchanged, no sample_valid.
- Undefined:
  - WAIT waits indefinitely; no counter logic.
  - timeout_err tied 0.

Test Plan:
- Reset check: rst_an=0 mid-LOAD → all outputs 0 immediately, state IDLE, pending=0.
- Frame load: write shadow[0]=10'h080, shadow[1]=10'h300, others 0, commit, tick → filt_coef_load high exactly 12 cycles presenting 080, 300, 000×10 in order; filt_start pulses the cycle after; frame_busy falls with load end.
- No-frame path: tick with exc_in=16'h0100, nothing pending → filt_coef_load stays 0; filt_start 1 cycle after tick; filt_sig=0100.
- Capture: model done 20 cycles after start with filt_out=16'hFF38 → sample_out=FF38 and sample_valid one cycle.
- Overrun/busy: a tick during WAIT sets overrun=1 and is not serviced; coef_wr to addr 3 while frame_busy=1 → shadow unchanged on the next load; a write to addr 13 is ignored.
- Timeout (macro defined, TIMEOUT=64): no done after start → IDLE after 64 cycles, timeout_err=1, no sample_valid; the next tick works normally.

Source files
------------

// File: rtl/filter_coef_sequencer.sv
// Sequencer for the FILTER coefficient/sample interface: streams committed coefficient frames, starts
// FILTER with an excitation sample and captures its output. FILTER_COEF_SEQUENCER_TIMEOUT_EN adds a WAIT-state abort.
module filter_coef_sequencer #(
  parameter int unsigned NCOEF  = 12,
  parameter int unsigned COEF_W = 10,
  parameter int unsigned SIG_W  = 16
`ifdef FILTER_COEF_SEQUENCER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              coef_wr,
  input  logic [3:0]        coef_waddr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              frame_commit,
  output logic              frame_busy,
  input  logic              sample_tick,
  input  logic [SIG_W-1:0]  exc_in,
  output logic [COEF_W-1:0] filt_coef,
  output logic              filt_coef_load,
  output logic [SIG_W-1:0]  filt_sig,
  output logic              filt_start,
  input  logic              filt_done,
  input  logic [SIG_W-1:0]  filt_out,
  output logic [SIG_W-1:0]  sample_out,
  output logic              sample_valid,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [COEF_W-1:0] r_shadow [NCOEF];

  logic [1:0]        r_state,   w_state_nxt;
  logic [IDX_W-1:0]  r_index,   w_index_nxt;
  logic [IDX_W-1:0]  w_index_inc;
  logic              r_pending, w_pending_nxt;
  logic [COEF_W-1:0] r_coef,    w_coef_nxt;
  logic              r_load,    w_load_nxt;
  logic [SIG_W-1:0]  r_sig,     w_sig_nxt;
  logic              r_start,   w_start_nxt;
  logic [SIG_W-1:0]  r_sout,    w_sout_nxt;
  logic              r_valid,   w_valid_nxt;
  logic              r_overrun, w_overrun_nxt;

`ifdef FILTER_COEF_SEQUENCER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic              r_tout,    w_tout_nxt;
`endif

  assign w_index_inc = r_index + IDX_W'(1);

  // Shadow bank is frozen while a frame is pending so the streamed frame is always coherent
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      for (int i = 0; i < NCOEF; i++) r_shadow[i] <= '0;
    end else if (coef_wr && !r_pending && (coef_waddr < IDX_W'(NCOEF))) begin
      r_shadow[coef_waddr] <= coef_wdata;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_index_nxt   = r_index;
    w_pending_nxt = r_pending;
    w_coef_nxt    = '0;
    w_load_nxt    = 1'b0;
    w_sig_nxt     = r_sig;
    w_start_nxt   = 1'b0;
    w_sout_nxt    = r_sout;
    w_valid_nxt   = 1'b0;
    w_overrun_nxt = r_overrun | (sample_tick && (r_state != S_IDLE));
`ifdef FILTER_COEF_SEQUENCER_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_tout_nxt    = r_tout;
`endif

    if (frame_commit && !r_pending) w_pending_nxt = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (sample_tick) begin
          w_sig_nxt = exc_in;
          if (r_pending) begin
            w_state_nxt = S_LOAD;
            w_index_nxt = '0;
            w_coef_nxt  = r_shadow[0];
            w_load_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_START;
            w_start_nxt = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (r_index == IDX_W'(NCOEF - 1)) begin
          w_state_nxt   = S_START;
          w_start_nxt   = 1'b1;
          w_pending_nxt = 1'b0;
          w_index_nxt   = '0;
        end else begin
          w_index_nxt = w_index_inc;
          w_coef_nxt  = r_shadow[w_index_inc];
          w_load_nxt  = 1'b1;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
`ifdef FILTER_COEF_SEQUENCER_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
      end
      S_WAIT: begin
        if (filt_done) begin
          w_sout_nxt  = filt_out;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef FILTER_COEF_SEQUENCER_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_IDLE;
          w_tout_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_state   <= S_IDLE;
      r_index   <= '0;
      r_pending <= 1'b0;
      r_coef    <= '0;
      r_load    <= 1'b0;
      r_sig     <= '0;
      r_start   <= 1'b0;
      r_sout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef FILTER_COEF_SEQUENCER_TIMEOUT_EN
      r_cnt     <= '0;
      r_tout    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_index   <= w_index_nxt;
      r_pending <= w_pending_nxt;
      r_coef    <= w_coef_nxt;
      r_load    <= w_load_nxt;
      r_sig     <= w_sig_nxt;
      r_start   <= w_start_nxt;
      r_sout    <= w_sout_nxt;
      r_valid   <= w_valid_nxt;
      r_overrun <= w_overrun_nxt;
`ifdef FILTER_COEF_SEQUENCER_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
      r_tout    <= w_tout_nxt;
`endif
    end
  end

  // Pending and busy share one flag: both span commit acceptance to end of load
  assign frame_busy     = r_pending;
  assign filt_coef      = r_coef;
  assign filt_coef_load = r_load;
  assign filt_sig       = r_sig;
  assign filt_start     = r_start;
  assign sample_out     = r_sout;
  assign sample_valid   = r_valid;
  assign overrun        = r_overrun;
`ifdef FILTER_COEF_SEQUENCER_TIMEOUT_EN
  assign timeout_err    = r_tout;
`else
  assign timeout_err    = 1'b0;
`endif

endmodule
